// File: rtl/vga_render_pipe_pkg.sv
// Shared definitions for the VGA render pipe: gamemode encodings,
// 12-bit RGB colour constants (R[11:8] G[7:4] B[3:0]) and pipeline depth.
package vga_render_pkg;

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_RUN   = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gamemode_e;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] ORANGE = 12'hF70;
  localparam logic [11:0] BLUE   = 12'h00F;

  // Pixel in -> colour out, in clock cycles (register stages).
  localparam int LATENCY = 2;

endpackage

// File: rtl/vga_render_pipe_if.sv
// Bus between game_logic / VGA timing (master) and the renderer (slave).
//   frame_start  1-cycle pulse before the first active pixel of a frame
//   pix_valid    active-video qualifier for pix_x/pix_y
//   pix_x/pix_y  current pixel
//   gamemode     00 init, 01 run, 10 pause, 11 over
//   player_y     player top edge
//   obstacle_x   slot i: [i*2XW +: XW] left, next XW right
//   obstacle_y   slot i: [i*2YW +: YW] top, next YW bottom
//   rgb          rendered colour, rgb_valid = pix_valid delayed
interface vga_render_pipe_if #(
  parameter int NUM_OBS = 10,
  parameter int XW      = 10,
  parameter int YW      = 9
);
  logic                    frame_start;
  logic                    pix_valid;
  logic [XW-1:0]           pix_x;
  logic [YW-1:0]           pix_y;
  logic [1:0]              gamemode;
  logic [YW-1:0]           player_y;
  logic [NUM_OBS*2*XW-1:0] obstacle_x;
  logic [NUM_OBS*2*YW-1:0] obstacle_y;
  logic [11:0]             rgb;
  logic                    rgb_valid;

  modport master (
    output frame_start, pix_valid, pix_x, pix_y, gamemode, player_y, obstacle_x, obstacle_y,
    input  rgb, rgb_valid
  );

  modport slave (
    input  frame_start, pix_valid, pix_x, pix_y, gamemode, player_y, obstacle_x, obstacle_y,
    output rgb, rgb_valid
  );
endinterface

// File: rtl/vga_render_pipe_obs_hit.sv
// Combinational box-hit test for one obstacle slot.
//   pix_x/pix_y   pixel under test
//   left/right    half-open column range [left, right)
//   top/bottom    half-open row range [top, bottom)
//   hit           pixel lies inside the box
// Half-open bounds make degenerate boxes (right<=left or bottom<=top, which
// includes the empty-slot encoding left==right && top==bottom) never hit.
module vga_obs_hit #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  input  logic [XW-1:0] left,
  input  logic [XW-1:0] right,
  input  logic [YW-1:0] top,
  input  logic [YW-1:0] bottom,
  output logic          hit
);
  assign hit = (pix_x >= left) && (pix_x < right) &&
               (pix_y >= top)  && (pix_y < bottom);
endmodule

// File: rtl/vga_render_pipe.sv
// Two-stage pixel renderer between game_logic and the VGA timing generator.
//   clk, rst_n   pixel clock, async active-low reset
//   bus          vga_render_pipe_if slave: pixel stream + game state in, rgb out
// Game state is latched into shadow registers on frame_start so a frame is
// rendered from one consistent snapshot. S1 classifies the pixel, S2 picks
// the colour by priority.
module vga_render_pipe
  import vga_render_pkg::*;
#(
  parameter int NUM_OBS     = 10,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int UPPER_BOUND = 20,
  parameter int LOWER_BOUND = 460,
  parameter int BLINK_LOG2  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_render_pipe_if.slave bus
);

  logic [1:0]              sh_mode,  cur_mode;
  logic [YW-1:0]           sh_py,    cur_py;
  logic [NUM_OBS*2*XW-1:0] sh_ox,    cur_ox;
  logic [NUM_OBS*2*YW-1:0] sh_oy,    cur_oy;
  logic [BLINK_LOG2:0]     frame_cnt, cur_cnt;

  // Effective state for the pixel in flight: a pixel arriving together with
  // frame_start already sees the new snapshot and the new frame count.
  always_comb begin
    cur_mode = sh_mode;
    cur_py   = sh_py;
    cur_ox   = sh_ox;
    cur_oy   = sh_oy;
    cur_cnt  = frame_cnt;
    if (bus.frame_start) begin
      cur_mode = bus.gamemode;
      cur_py   = bus.player_y;
      cur_ox   = bus.obstacle_x;
      cur_oy   = bus.obstacle_y;
      // Counter runs in run/pause/over and is cleared while in init.
      cur_cnt  = (bus.gamemode == GM_INIT) ? '0 : frame_cnt + (BLINK_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mode   <= GM_INIT;
      sh_py     <= '0;
      sh_ox     <= '0;
      sh_oy     <= '0;
      frame_cnt <= '0;
    end else begin
      sh_mode   <= cur_mode;
      sh_py     <= cur_py;
      sh_ox     <= cur_ox;
      sh_oy     <= cur_oy;
      frame_cnt <= cur_cnt;
    end
  end

  // ---- S1 classification ----
  logic               border, player_hit;
  logic [YW:0]        py_end;
  logic [NUM_OBS-1:0] obs_vec;

  assign border = (bus.pix_y <= YW'(UPPER_BOUND)) || (bus.pix_y >= YW'(LOWER_BOUND));

  // Extra bit keeps py+PLAYER_SIZE from wrapping near the bottom of the screen.
  assign py_end     = {1'b0, cur_py} + (YW+1)'(PLAYER_SIZE);
  assign player_hit = (bus.pix_x >= XW'(PLAYER_X)) &&
                      ({1'b0, bus.pix_x} < (XW+1)'(PLAYER_X + PLAYER_SIZE)) &&
                      (bus.pix_y >= cur_py) && ({1'b0, bus.pix_y} < py_end);

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_obs
    vga_obs_hit #(.XW(XW), .YW(YW)) u_hit (
      .pix_x  (bus.pix_x),
      .pix_y  (bus.pix_y),
      .left   (cur_ox[i*2*XW      +: XW]),
      .right  (cur_ox[i*2*XW + XW +: XW]),
      .top    (cur_oy[i*2*YW      +: YW]),
      .bottom (cur_oy[i*2*YW + YW +: YW]),
      .hit    (obs_vec[i])
    );
  end

  logic [LATENCY:1] vld_pipe;
  logic             s1_border, s1_player, s1_obs, s1_blink;
  gamemode_e        s1_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_border <= 1'b0;
      s1_player <= 1'b0;
      s1_obs    <= 1'b0;
      s1_blink  <= 1'b0;
      s1_mode   <= GM_INIT;
    end else begin
      vld_pipe  <= {vld_pipe[LATENCY-1:1], bus.pix_valid};
      s1_border <= border;
      s1_player <= player_hit;
      s1_obs    <= |obs_vec;
      s1_blink  <= cur_cnt[BLINK_LOG2];
      s1_mode   <= gamemode_e'(cur_mode);
    end
  end

  // ---- S2 colour priority ----
  logic [11:0] colour, rgb_q;

  always_comb begin
    colour = BLACK;
    if (!vld_pipe[1] || s1_border)                          colour = BLACK;
    else if (s1_mode == GM_INIT)                            colour = GREEN;
    else if (s1_player && !(s1_mode == GM_OVER && s1_blink))  colour = BLUE;
    else if (s1_obs && !(s1_mode == GM_PAUSE && s1_blink))    colour = ORANGE;
    else begin
      case (s1_mode)
        GM_RUN:   colour = WHITE;
        GM_PAUSE: colour = YELLOW;
        default:  colour = RED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= BLACK;
    else        rgb_q <= colour;
  end

  assign bus.rgb       = rgb_q;
  assign bus.rgb_valid = vld_pipe[LATENCY];

endmodule

// File: tb/tb_vga_render_pipe.sv
module tb_vga_render_pipe;
  localparam int NOBS = 10;
  localparam int XW   = 10;
  localparam int YW   = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_render_pipe_if #(.NUM_OBS(NOBS), .XW(XW), .YW(YW)) bus();
  vga_render_pipe #(.NUM_OBS(NOBS), .XW(XW), .YW(YW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int ntests = 0;
  int nfail  = 0;

  // Values the bench is currently driving (d_*) and the model's latched frame (m_*).
  int d_mode, d_py;
  int d_l[NOBS], d_r[NOBS], d_t[NOBS], d_b[NOBS];
  int m_mode, m_py, m_cnt;
  int m_l[NOBS], m_r[NOBS], m_t[NOBS], m_b[NOBS];

  logic [12:0] exp_q[$];
  string       tag_q[$];

  // Reference colour for a pixel, straight from the rendering rules.
  function automatic logic [11:0] ref_colour(int x, int y, bit v);
    bit blink, ph, oh;
    blink = ((m_cnt / 16) % 2) == 1;
    if (!v) return 12'h000;
    if (y <= 20 || y >= 460) return 12'h000;
    if (m_mode == 0) return 12'h0F0;
    ph = (x >= 160) && (x < 200) && (y >= m_py) && (y < m_py + 40);
    oh = 1'b0;
    for (int i = 0; i < NOBS; i++)
      if (x >= m_l[i] && x < m_r[i] && y >= m_t[i] && y < m_b[i]) oh = 1'b1;
    if (ph && !(m_mode == 3 && blink)) return 12'h00F;
    if (oh && !(m_mode == 2 && blink)) return 12'hF70;
    case (m_mode)
      1:       return 12'hFFF;
      2:       return 12'hFF0;
      default: return 12'hF00;
    endcase
  endfunction

  task automatic check(string tag, logic [12:0] got, logic [12:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got valid=%0b rgb=%03h, want valid=%0b rgb=%03h",
             tag, got[12], got[11:0], exp[12], exp[11:0]);
    end
  endtask

  task automatic drive_geom();
    bus.gamemode = 2'(d_mode);
    bus.player_y = YW'(d_py);
    for (int i = 0; i < NOBS; i++) begin
      bus.obstacle_x[i*2*XW      +: XW] = XW'(d_l[i]);
      bus.obstacle_x[i*2*XW + XW +: XW] = XW'(d_r[i]);
      bus.obstacle_y[i*2*YW      +: YW] = YW'(d_t[i]);
      bus.obstacle_y[i*2*YW + YW +: YW] = YW'(d_b[i]);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_py = 0; m_cnt = 0;
    for (int i = 0; i < NOBS; i++) begin m_l[i] = 0; m_r[i] = 0; m_t[i] = 0; m_b[i] = 0; end
    exp_q.delete(); tag_q.delete();
    exp_q.push_back(13'h0); tag_q.push_back("pipe_after_reset");
  endtask

  // One clock: model samples what the bench drives, output from the previous sample is checked.
  task automatic tick(string tag);
    logic [12:0] e;
    string t;
    @(posedge clk);
    if (bus.frame_start) begin
      m_mode = d_mode; m_py = d_py;
      for (int i = 0; i < NOBS; i++) begin
        m_l[i] = d_l[i]; m_r[i] = d_r[i]; m_t[i] = d_t[i]; m_b[i] = d_b[i];
      end
      m_cnt = (d_mode == 0) ? 0 : (m_cnt + 1) % 32;
    end
    exp_q.push_back({bus.pix_valid, ref_colour(int'(bus.pix_x), int'(bus.pix_y), bus.pix_valid)});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {bus.rgb_valid, bus.rgb}, e);
  endtask

  task automatic px(int x, int y, string tag);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b1;
    bus.pix_x       = XW'(x);
    bus.pix_y       = YW'(y);
    tick(tag);
  endtask

  task automatic idle(string tag);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    tick(tag);
  endtask

  task automatic frame(int mode);
    d_mode = mode;
    drive_geom();
    bus.frame_start = 1'b1;
    bus.pix_valid   = 1'b0;
    tick("frame_start");
    bus.frame_start = 1'b0;
  endtask

  task automatic set_slot(int i, int l, int r, int t, int b);
    d_l[i] = l; d_r[i] = r; d_t[i] = t; d_b[i] = b;
    drive_geom();
  endtask

  initial begin
    d_mode = 0; d_py = 0;
    for (int i = 0; i < NOBS; i++) begin d_l[i] = 0; d_r[i] = 0; d_t[i] = 0; d_b[i] = 0; end
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
    drive_geom();
    model_reset();

    // 1: reset state, then obstacle slot0
    #12;
    check("reset_out", {bus.rgb_valid, bus.rgb}, 13'h0);
    @(negedge clk); rst_n = 1'b1;
    set_slot(0, 300, 340, 100, 200);
    frame(1);
    px(300, 100, "obs_corner");
    px(340, 100, "obs_right_excl");
    idle("t1_idle"); idle("t1_idle");

    // 2: player
    d_py = 200;
    set_slot(1, 165, 180, 205, 220);
    frame(1);
    px(160, 200, "player_tl");
    px(199, 239, "player_br");
    px(200, 239, "player_right_excl");
    px(170, 210, "player_over_obs");
    px(175, 240, "player_bottom_excl");

    // 3: border rows and invalid pixel
    px(300, 20,  "border_y20");
    px(300, 21,  "row_y21");
    px(300, 459, "row_y459");
    px(300, 460, "border_y460");
    idle("pix_invalid");
    idle("pix_invalid2");

    // 4: mid-frame change is invisible until next frame_start; empty slot
    set_slot(0, 500, 540, 100, 200);
    set_slot(2, 50, 50, 50, 50);
    px(300, 100, "old_box_persists");
    px(510, 150, "new_box_not_yet");
    frame(1);
    px(300, 100, "old_box_gone");
    px(510, 150, "new_box_live");
    px(50, 50, "empty_slot");

    // 5: pause entered with blink bit set, then game over blinking
    while (m_cnt != 15) frame(1);
    frame(2);
    px(510, 150, "pause_hidden");
    px(600, 300, "pause_bg");
    for (int k = 0; k < 10; k++) begin
      frame(2);
      px(520, 160, "pause_steady");
    end
    for (int k = 0; k < 40; k++) begin
      frame(3);
      px(185, 230, "over_blink");
    end

    // 6: init mode shows only background, then async reset mid-line
    set_slot(0, 300, 340, 100, 200);
    frame(0);
    for (int y = 21; y <= 459; y += 31) px(310, y, "init_green");
    px(170, 230, "init_player_hidden");
    bus.pix_valid = 1'b1; bus.pix_x = XW'(250); bus.pix_y = YW'(300);
    #1 rst_n = 1'b0;
    #1 check("async_rst", {bus.rgb_valid, bus.rgb}, 13'h0);
    #1 rst_n = 1'b1;
    model_reset();
    px(250, 300, "post_rst");
    px(320, 150, "post_rst_no_obs");
    px(170, 300, "post_rst_no_player");

    // Random pixels, geometry and frame changes (geometry may also change mid-frame).
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        d_mode = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
        d_py   = int'($urandom_range(0, 479));
        for (int i = 0; i < NOBS; i++) begin
          d_l[i] = int'($urandom_range(0, 600));
          d_r[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 639)) : d_l[i] + int'($urandom_range(0, 120));
          d_t[i] = int'($urandom_range(0, 450));
          d_b[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 479)) : d_t[i] + int'($urandom_range(0, 100));
          if (d_r[i] > 1023) d_r[i] = 1023;
          if (d_b[i] > 511)  d_b[i] = 511;
        end
        drive_geom();
      end
      bus.frame_start = ($urandom_range(0, 19) == 0);
      bus.pix_valid   = ($urandom_range(0, 3) != 0);
      bus.pix_x       = XW'($urandom_range(0, 639));
      bus.pix_y       = YW'($urandom_range(0, 479));
      tick("rand");
    end
    idle("flush");
    idle("flush");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
